// File: rtl/load_align_unit.sv
// Load path between MEM and the L1 data cache read port: issues one or two
// aligned word reads, merges them and returns the sign/zero-extended result.
module load_align_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_type,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_fault
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_REQ1, S_WAIT1, S_REQ2, S_WAIT2, S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            type_q;
    logic [DATA_WIDTH-1:0] lo_q, hi_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic                  resp_fault_q;

    function automatic logic [3:0] size_of(input logic [2:0] t);
        return 4'd1 << t[1:0];
    endfunction

    function automatic logic is_illegal(input logic [2:0] t);
        return (t == 3'b111) || ((DATA_WIDTH == 32) && (t == 3'b011 || t == 3'b110));
    endfunction

    function automatic logic crosses(input logic [OFS-1:0] off, input logic [2:0] t);
        return (5'(off) + 5'(size_of(t))) > 5'(BYTES);
    endfunction

    logic req_illegal, req_cross, cross_q;
    logic [ADDR_WIDTH-1:0] base_q;

    assign req_illegal = is_illegal(req_type);
    assign req_cross   = crosses(req_addr[OFS-1:0], req_type);
    assign cross_q     = crosses(addr_q[OFS-1:0], type_q);
    assign base_q      = {addr_q[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};

    // Merge the incoming beat with the stored one, then shift out the offset and extend.
    logic [DATA_WIDTH-1:0] lo_next, hi_next, aligned, size_mask, sign_mask, merged;
    logic [6:0]            nbits;

    always_comb begin
        lo_next = lo_q;
        hi_next = hi_q;
        if (state_q == S_WAIT2) begin
            hi_next = mem_resp_data;
        end else begin
            lo_next = mem_resp_data;
        end
        nbits     = {size_of(type_q), 3'b000};
        aligned   = DATA_WIDTH'({hi_next, lo_next} >> {addr_q[OFS-1:0], 3'b000});
        size_mask = ~({DATA_WIDTH{1'b1}} << nbits);
        sign_mask = ONE << (nbits - 7'd1);
        merged    = aligned & size_mask;
        if (!type_q[2] && (|(aligned & sign_mask))) begin
            merged = merged | ~size_mask;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_illegal || (req_cross && !MISALIGN_EN)) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_REQ1;
                    end
                end
            end
            S_REQ1:  if (mem_req_ready)  state_d = S_WAIT1;
            S_WAIT1: if (mem_resp_valid) state_d = cross_q ? S_REQ2 : S_RESP;
            S_REQ2:  if (mem_req_ready)  state_d = S_WAIT2;
            S_WAIT2: if (mem_resp_valid) state_d = S_RESP;
            S_RESP:  if (resp_ready)     state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            type_q       <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            resp_data_q  <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q       <= req_addr;
                        type_q       <= req_type;
                        lo_q         <= '0;
                        hi_q         <= '0;
                        resp_data_q  <= '0;
                        resp_fault_q <= !req_illegal && req_cross && !MISALIGN_EN;
                    end
                end
                S_WAIT1: begin
                    if (mem_resp_valid) begin
                        lo_q <= lo_next;
                        if (!cross_q) resp_data_q <= merged;
                    end
                end
                S_WAIT2: begin
                    if (mem_resp_valid) begin
                        hi_q        <= hi_next;
                        resp_data_q <= merged;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign mem_req_valid = (state_q == S_REQ1) || (state_q == S_REQ2);
    assign mem_req_addr  = (state_q == S_REQ2) ? base_q + ADDR_WIDTH'(BYTES) : base_q;
    assign resp_valid    = (state_q == S_RESP);
    assign resp_data     = resp_data_q;
    assign resp_fault    = resp_fault_q;
endmodule

// File: tb/tb_load_align_unit.sv
// Randomized bench for load_align_unit: three configurations share one driver
// and a byte-level memory/load model.
module tb_load_align_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, mem_req_ready, mem_resp_valid, resp_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_type;
    logic [63:0] mem_resp_data;
    int          sel;

    logic        rv_a, rv_b, rv_c, mv_a, mv_b, mv_c;
    logic        rr_a, rr_b, rr_c, mqv_a, mqv_b, mqv_c, vv_a, vv_b, vv_c, f_a, f_b, f_c;
    logic [31:0] ma_a, ma_b, ma_c, d_a, d_b;
    logic [63:0] d_c;

    logic        o_req_ready, o_mem_req_valid, o_resp_valid, o_resp_fault;
    logic [31:0] o_mem_req_addr;
    logic [63:0] o_resp_data;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [63:0] last_data;
    logic        last_fault;
    logic [7:0]  mem [logic [31:0]];

    always #5 clk = ~clk;

    assign rv_a = (sel == 0) && req_valid;
    assign rv_b = (sel == 1) && req_valid;
    assign rv_c = (sel == 2) && req_valid;
    assign mv_a = (sel == 0) && mem_resp_valid;
    assign mv_b = (sel == 1) && mem_resp_valid;
    assign mv_c = (sel == 2) && mem_resp_valid;

    load_align_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MISALIGN_EN(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .req_valid(rv_a), .req_ready(rr_a),
        .req_addr(req_addr), .req_type(req_type), .mem_req_valid(mqv_a),
        .mem_req_ready(mem_req_ready), .mem_req_addr(ma_a), .mem_resp_valid(mv_a),
        .mem_resp_data(mem_resp_data[31:0]), .resp_valid(vv_a), .resp_ready(resp_ready),
        .resp_data(d_a), .resp_fault(f_a));

    load_align_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MISALIGN_EN(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid(rv_b), .req_ready(rr_b),
        .req_addr(req_addr), .req_type(req_type), .mem_req_valid(mqv_b),
        .mem_req_ready(mem_req_ready), .mem_req_addr(ma_b), .mem_resp_valid(mv_b),
        .mem_resp_data(mem_resp_data[31:0]), .resp_valid(vv_b), .resp_ready(resp_ready),
        .resp_data(d_b), .resp_fault(f_b));

    load_align_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .MISALIGN_EN(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .req_valid(rv_c), .req_ready(rr_c),
        .req_addr(req_addr), .req_type(req_type), .mem_req_valid(mqv_c),
        .mem_req_ready(mem_req_ready), .mem_req_addr(ma_c), .mem_resp_valid(mv_c),
        .mem_resp_data(mem_resp_data), .resp_valid(vv_c), .resp_ready(resp_ready),
        .resp_data(d_c), .resp_fault(f_c));

    always_comb begin
        o_req_ready     = rr_a;
        o_mem_req_valid = mqv_a;
        o_mem_req_addr  = ma_a;
        o_resp_valid    = vv_a;
        o_resp_data     = {32'h0, d_a};
        o_resp_fault    = f_a;
        if (sel == 1) begin
            o_req_ready = rr_b; o_mem_req_valid = mqv_b; o_mem_req_addr = ma_b;
            o_resp_valid = vv_b; o_resp_data = {32'h0, d_b}; o_resp_fault = f_b;
        end else if (sel == 2) begin
            o_req_ready = rr_c; o_mem_req_valid = mqv_c; o_mem_req_addr = ma_c;
            o_resp_valid = vv_c; o_resp_data = d_c; o_resp_fault = f_c;
        end
    end

    function automatic int cur_bytes();
        return (sel == 2) ? 8 : 4;
    endfunction

    function automatic bit cur_me();
        return sel != 1;
    endfunction

    // Unwritten bytes read back as a fixed hash of their address.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic logic [63:0] word_at(input logic [31:0] base);
        logic [63:0] w;
        w = '0;
        for (int j = 0; j < cur_bytes(); j++) w[8*j +: 8] = mem_byte(base + 32'(j));
        return w;
    endfunction

    task automatic set_bytes(input logic [31:0] a, input logic [63:0] v, input int n);
        for (int j = 0; j < n; j++) mem[a + 32'(j)] = v[8*j +: 8];
    endtask

    // Reference: gather the addressed bytes one by one, then extend.
    function automatic void model_load(input logic [31:0] a, input logic [2:0] t,
                                       output logic [63:0] d, output logic f, output int nr,
                                       output logic [31:0] r0, output logic [31:0] r1);
        int  size, w, off;
        bit  illegal;
        w       = cur_bytes();
        size    = 1 << t[1:0];
        illegal = (t == 3'd7) || (w == 4 && (t == 3'd3 || t == 3'd6));
        d  = '0;
        f  = 1'b0;
        nr = 0;
        r0 = a & ~32'(w - 1);
        r1 = r0 + 32'(w);
        off = int'(a - r0);
        if (illegal) return;
        if (off + size > w && !cur_me()) begin
            f = 1'b1;
            return;
        end
        nr = (off + size > w) ? 2 : 1;
        for (int i = 0; i < size; i++) d[8*i +: 8] = mem_byte(a + 32'(i));
        if (!t[2] && d[8*size-1]) begin
            for (int i = 8*size; i < 64; i++) d[i] = 1'b1;
        end
        if (w == 4) d[63:32] = '0;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h expected %h (sel %0d)", tag, got, exp, sel);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [2:0] t,
                                 input int mstall, input int rdelay, input int rstall);
        logic [63:0] exp_d, held_data;
        logic        exp_f;
        int          exp_nr, exp_lat, n, lat, mwait, rwait, cd;
        logic [31:0] exp_r0, exp_r1, held_addr, pend_addr;
        logic [31:0] got_addr[$];
        bit          pend, done;
        model_load(a, t, exp_d, exp_f, exp_nr, exp_r0, exp_r1);
        exp_lat = (exp_nr == 0) ? 1 : (exp_nr == 1) ? 3 : 5;
        @(negedge clk);
        checkOutput("req_ready_idle", o_req_ready, 1);
        req_valid = 1'b1; req_addr = a; req_type = t;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1; lat = -1; mwait = 0; rwait = 0; cd = 0; pend = 0; done = 0;
        held_addr = '0; pend_addr = '0; held_data = '0;
        while (!done && n < 300) begin
            mem_resp_valid = 1'b0;
            if (pend) begin
                if (cd == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = word_at(pend_addr);
                    pend = 0;
                end else cd--;
            end
            mem_req_ready = 1'b0;
            if (o_mem_req_valid) begin
                if (mwait > 0) begin
                    checkOutput("mem_addr_stable", o_mem_req_addr, held_addr);
                    checkOutput("req_ready_stall", o_req_ready, 0);
                end
                held_addr = o_mem_req_addr;
                if (mwait >= mstall) begin
                    mem_req_ready = 1'b1;
                    got_addr.push_back(o_mem_req_addr);
                    pend_addr = o_mem_req_addr;
                    pend = 1; cd = rdelay; mwait = 0;
                end else mwait++;
            end
            resp_ready = 1'b0;
            if (o_resp_valid) begin
                if (lat < 0) begin
                    lat = n;
                    held_data = o_resp_data;
                end else begin
                    checkOutput("resp_data_stable", o_resp_data, held_data);
                    checkOutput("req_ready_resp", o_req_ready, 0);
                end
                if (rwait >= rstall) begin
                    resp_ready = 1'b1;
                    last_fault = o_resp_fault;
                    done = 1;
                end else rwait++;
            end
            @(negedge clk);
            n++;
        end
        resp_ready = 1'b0; mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
        checkOutput("no_timeout", 64'(done), 1);
        last_data = held_data;
        checkOutput("resp_data", held_data, exp_d);
        checkOutput("resp_fault", 64'(last_fault), 64'(exp_f));
        checkOutput("mem_reads", 64'(got_addr.size()), 64'(exp_nr));
        if (got_addr.size() > 0 && exp_nr > 0) checkOutput("mem_addr0", got_addr[0], exp_r0);
        if (got_addr.size() > 1 && exp_nr > 1) checkOutput("mem_addr1", got_addr[1], exp_r1);
        if (mstall == 0 && rdelay == 0) checkOutput("latency", 64'(lat), 64'(exp_lat));
        checkOutput("resp_valid_drop", o_resp_valid, 0);
        checkOutput("req_ready_back", o_req_ready, 1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_req_ready"}, o_req_ready, 1);
        checkOutput({tag, "_mem_req_valid"}, o_mem_req_valid, 0);
        checkOutput({tag, "_mem_req_addr"}, o_mem_req_addr, 0);
        checkOutput({tag, "_resp_valid"}, o_resp_valid, 0);
        checkOutput({tag, "_resp_data"}, o_resp_data, 0);
        checkOutput({tag, "_resp_fault"}, o_resp_fault, 0);
    endtask

    task automatic resetDuringWait();
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h100; req_type = 3'b010; mem_req_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rst_req1", o_mem_req_valid, 1);
        @(negedge clk);
        mem_req_ready = 1'b0;
        checkOutput("rst_in_wait", o_mem_req_valid, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = word_at(32'h100);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        checkResetState("rst_wait");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rst_no_resp", o_resp_valid, 0);
            checkOutput("rst_stay_idle", o_req_ready, 1);
        end
    endtask

    function automatic int rnd_stall();
        return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
    endfunction

    task automatic runRandom(input int count);
        logic [31:0] a;
        for (int i = 0; i < count; i++) begin
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                           a = 32'h100 + 32'($urandom_range(0, 31));
            applyStimulus(a, 3'($urandom_range(0, 7)), rnd_stall(), rnd_stall(), rnd_stall());
        end
    endtask

    initial begin
        rst_n = 1'b0; sel = 0;
        req_valid = 1'b0; req_addr = '0; req_type = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; resp_ready = 1'b0;
        last_data = '0; last_fault = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1 checkResetState("reset");
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;

        set_bytes(32'h100, 64'h887766F5, 4);
        set_bytes(32'h104, 64'hCCBBAA99, 4);
        set_bytes(32'hFFFF_FFFC, 64'h44332211, 4);
        set_bytes(32'h0, 64'hDDCCBBAA, 4);
        applyStimulus(32'h100, 3'b000, 0, 0, 0);
        checkOutput("lb_100", last_data, 64'hFFFF_FFF5);
        applyStimulus(32'h103, 3'b100, 0, 0, 0);
        checkOutput("lbu_103", last_data, 64'h88);
        applyStimulus(32'h103, 3'b001, 0, 0, 0);
        checkOutput("lh_103", last_data, 64'hFFFF_9988);
        applyStimulus(32'h102, 3'b010, 0, 0, 0);
        checkOutput("lw_102", last_data, 64'hAA99_8877);
        applyStimulus(32'h100, 3'b010, 4, 2, 5);
        checkOutput("lw_100_stall", last_data, 64'h8877_66F5);
        applyStimulus(32'h101, 3'b111, 0, 0, 0);
        applyStimulus(32'h100, 3'b011, 0, 0, 0);
        applyStimulus(32'hFFFF_FFFE, 3'b010, 0, 0, 0);
        checkOutput("lw_wrap", last_data, 64'hBBAA_4433);
        resetDuringWait();
        runRandom(150);

        sel = 1;
        applyStimulus(32'h101, 3'b010, 0, 0, 0);
        checkOutput("fault_lw_101", 64'(last_fault), 1);
        checkOutput("fault_lw_101_data", last_data, 0);
        applyStimulus(32'h102, 3'b001, 0, 0, 0);
        checkOutput("lh_102_nf", last_data, 64'hFFFF_8877);
        applyStimulus(32'h103, 3'b101, 2, 0, 3);
        runRandom(60);

        sel = 2;
        mem.delete();
        set_bytes(32'h100, 64'h8000_0000_1234_5678, 8);
        set_bytes(32'h108, 64'h0F1E_2D3C_4B5A_6978, 8);
        applyStimulus(32'h100, 3'b011, 0, 0, 0);
        checkOutput("ld_100", last_data, 64'h8000_0000_1234_5678);
        applyStimulus(32'h104, 3'b110, 0, 0, 0);
        checkOutput("lwu_104", last_data, 64'h0000_0000_8000_0000);
        applyStimulus(32'h104, 3'b010, 0, 0, 0);
        checkOutput("lw_104", last_data, 64'hFFFF_FFFF_8000_0000);
        applyStimulus(32'h104, 3'b011, 0, 0, 0);
        checkOutput("ld_104_split", last_data, 64'h4B5A_6978_8000_0000);
        runRandom(150);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/load_align_unit.md
# load_align_unit

Multi-cycle load data path between the pipeline's MEM stage and the L1 data cache read port. Accepts one load (address + funct3) per handshake, issues one or two aligned word reads to the cache, and returns a right-justified, sign- or zero-extended result. It generalises the existing combinational load extractor in three ways: a parametrised data width (32/64), the RV64 load types, and optional hardware split-and-merge of misaligned loads that cross a word boundary, with a fault response when that option is disabled.

## Interface
- DATA_WIDTH, 32, bus/register width; 32 or 64. BYTES = DATA_WIDTH/8, OFS = log2(BYTES).
- ADDR_WIDTH, 32, byte-address width.
- MISALIGN_EN, 1, 1 = split boundary-crossing loads into two reads; 0 = return fault.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  load request valid.
- req_ready  out  1  high only in IDLE.
- req_addr  in  ADDR_WIDTH  byte address.
- req_type  in  3  funct3: lb 000, lh 001, lw 010, ld 011, lbu 100, lhu 101, lwu 110.
- mem_req_valid  out  1  cache read request.
- mem_req_ready  in  1  cache accepts request.
- mem_req_addr  out  ADDR_WIDTH  word-aligned address (low OFS bits zero).
- mem_resp_valid  in  1  read data valid.
- mem_resp_data  in  DATA_WIDTH  read data.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  DATA_WIDTH  extended load result.
- resp_fault  out  1  misaligned-access fault (MISALIGN_EN=0 only).

## Operation
- Size: b = 1, h = 2, w = 4, d = 8 bytes. The type is illegal when it is 111, or when it is ld/lwu with DATA_WIDTH=32. Illegal types go straight to RESP with data 0, fault 0, and no memory access.
- Offset off = req_addr[OFS-1:0]. Base = req_addr with the low OFS bits cleared. The load crosses a word boundary when off + size > BYTES.
- The FSM has six states: IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP.
- IDLE:
  - On req_valid, latch the address and type.
  - If the type is illegal, go to RESP.
  - Else, if the load crosses and MISALIGN_EN=0, go to RESP with fault 1 and data 0.
  - Else go to REQ1.
- REQ1: mem_req_valid=1, mem_req_addr=base. When mem_req_ready is high, go to WAIT1.
- WAIT1: on mem_resp_valid, capture lo = mem_resp_data. If crossing, go to REQ2; else go to RESP.
- REQ2: mem_req_addr = base + BYTES, modulo 2^ADDR_WIDTH (wraps at the top of memory). When mem_req_ready is high, go to WAIT2.
- WAIT2: on mem_resp_valid, capture hi, then go to RESP.
- Merge: form {hi,lo} (hi = 0 when not crossing), shift it right by off*8, and keep the low size bytes.
  - lb/lh/lw/ld: sign-extend to DATA_WIDTH.
  - lbu/lhu/lwu: zero-extend.
- RESP: resp_valid=1, with resp_data and resp_fault held stable until resp_ready is high, then go to IDLE.
- mem_resp_valid outside WAIT1/WAIT2 is ignored.
- Reset:
  - Any state returns to IDLE.
  - All outputs go to 0 except req_ready, which is 1 after reset.
  - The internal lo/hi registers clear to 0.
  - A cache response still in flight after reset is ignored (the unit is in IDLE).

## Timing
- All outputs are decoded from registered state. resp_data and resp_fault are registers.
- mem_req_valid/addr stay stable until accepted. There is no combinational path from req_valid to mem_req_valid.
- Aligned load, cache ready and responding one cycle after acceptance:
  - request accepted at cycle 0;
  - REQ1 at cycle 1 (handshake);
  - WAIT1 at cycle 2 (response);
  - resp_valid at cycle 3.
- Crossing load: resp_valid at cycle 5.
- Fault or illegal type: resp_valid at cycle 1.
- Throughput: the next request can be accepted the cycle after the resp handshake (req_ready is high in IDLE).
- Stalls on mem_req_ready, mem_resp_valid or resp_ready extend the current state indefinitely, with no loss of data.

## Test plan
Test memory, DATA_WIDTH=32: word 0x100 = 0x887766F5, word 0x104 = 0xCCBBAA99.

1. Byte loads: lb @0x100 -> 0xFFFFFFF5; lbu @0x103 -> 0x00000088. Each issues exactly one mem read at 0x100, and resp_valid arrives 3 cycles after acceptance.
2. Misaligned loads, MISALIGN_EN=1:
   - lh @0x103 -> reads at 0x100 then 0x104, result 0xFFFF9988, latency 5.
   - lw @0x102 -> 0xAA998877.
3. Fault, MISALIGN_EN=0: lw @0x101 -> resp_fault=1, resp_data=0, mem_req_valid never asserted, resp_valid at cycle 1. Illegal type 111 -> data 0, fault 0.
4. Backpressure and reset:
   - Hold mem_req_ready low for 4 cycles, then resp_ready low for 5 cycles: the address and resp_data stay stable and req_ready stays 0.
   - Assert rst_n=0 during WAIT1, then deliver a late mem_resp_valid: the unit stays IDLE and no resp_valid appears.
5. Wrap-around: lw @0xFFFFFFFE -> second mem_req_addr = 0x00000000, and the result merges the top halfword of the last word with the low halfword of word 0.
6. DATA_WIDTH=64, with word 0x100 = 0x8000000012345678:
   - ld @0x100 -> the full word.
   - lwu @0x104 -> 0x0000000080000000.
   - lw @0x104 -> 0xFFFFFFFF80000000.
   - ld @0x104 splits into reads at 0x100 and 0x108.
